// File: rtl/hazard_ctrl.sv
// Load-use hazard detection and pipeline stall/bubble control with a stall watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned N_ISSUE  = 2,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_ISSUE-1:0]          de_valid,
    input  logic [N_ISSUE*REG_AW-1:0]   de_rs,
    input  logic [N_ISSUE*REG_AW-1:0]   de_rt,
    input  logic                        ex_load_valid,
    input  logic [REG_AW-1:0]           ex_load_rd,
    input  logic                        if_stall_i,
    input  logic                        ex_stall_i,
    input  logic                        mem_stall_i,
    input  logic                        flush_i,
    output logic                        if_id_stall_o,
    output logic                        id_ex_stall_o,
    output logic                        ex_mem_stall_o,
    output logic                        id_ex_bubble_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0]                 lu_cnt_o,
    output logic [31:0]                 mem_cnt_o,
`endif
    output logic                        stall_timeout_o
);

    localparam int unsigned NE = LOAD_LAT - 1;
    localparam int unsigned NA = (NE > 0) ? NE : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic              pend_v_q  [NA];
    logic              pend_v_d  [NA];
    logic [REG_AW-1:0] pend_rd_q [NA];
    logic [REG_AW-1:0] pend_rd_d [NA];

    logic [CW-1:0]     wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;

    logic              any_match;
    logic              load_use;
    logic              stall_raw;
    logic [REG_AW-1:0] src;

    // Scoreboard shifts only when EX/MEM advances; with LOAD_LAT=1 it never holds anything.
    always_comb begin
        for (int unsigned k = 0; k < NA; k++) begin
            pend_v_d[k]  = pend_v_q[k];
            pend_rd_d[k] = pend_rd_q[k];
        end
        if (!mem_stall_i) begin
            for (int unsigned k = NA - 1; k > 0; k--) begin
                pend_v_d[k]  = pend_v_q[k-1];
                pend_rd_d[k] = pend_rd_q[k-1];
            end
            pend_v_d[0]  = ex_load_valid;
            pend_rd_d[0] = ex_load_rd;
        end
        if (NE == 0) begin
            pend_v_d[0] = 1'b0;
        end
    end

    always_comb begin
        any_match = 1'b0;
        src       = '0;
        for (int unsigned i = 0; i < N_ISSUE; i++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                src = (s == 0) ? de_rs[i*REG_AW +: REG_AW] : de_rt[i*REG_AW +: REG_AW];
                if (de_valid[i] && (src != '0)) begin
                    if (ex_load_valid && (src == ex_load_rd)) begin
                        any_match = 1'b1;
                    end
                    for (int unsigned k = 0; k < NA; k++) begin
                        if (pend_v_q[k] && (src == pend_rd_q[k])) begin
                            any_match = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign load_use  = any_match & ~flush_i;
    assign stall_raw = if_stall_i | ex_stall_i | mem_stall_i | load_use;

    // Saturating at TIMEOUT keeps the counter from ever wrapping back to zero.
    always_comb begin
        wd_cnt_d = '0;
        if (stall_raw) begin
            wd_cnt_d = (wd_cnt_q == CW'(TIMEOUT)) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (wd_cnt_d == CW'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NA; k++) begin
                pend_v_q[k]  <= 1'b0;
                pend_rd_q[k] <= '0;
            end
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NA; k++) begin
                pend_v_q[k]  <= pend_v_d[k];
                pend_rd_q[k] <= pend_rd_d[k];
            end
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign if_id_stall_o   = ~rst & stall_raw;
    assign id_ex_stall_o   = ~rst & mem_stall_i;
    assign ex_mem_stall_o  = ~rst & mem_stall_i;
    assign id_ex_bubble_o  = ~rst & load_use & ~mem_stall_i & ~ex_stall_i;
    assign stall_timeout_o = ~rst & timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic [31:0] mem_cnt_q, mem_cnt_d;

    assign lu_cnt_d  = lu_cnt_q + {31'b0, load_use};
    assign mem_cnt_d = mem_cnt_q + {31'b0, mem_stall_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end

    assign lu_cnt_o  = rst ? '0 : lu_cnt_q;
    assign mem_cnt_o = rst ? '0 : mem_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors are queued per step and
// compared at the following falling clock edge.
module tb_hazard_ctrl;

    localparam int unsigned N_ISSUE  = 2;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned LOAD_LAT = 2;
    localparam int unsigned TIMEOUT  = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_ISSUE-1:0]        de_valid;
    logic [N_ISSUE*REG_AW-1:0] de_rs;
    logic [N_ISSUE*REG_AW-1:0] de_rt;
    logic                      ex_load_valid;
    logic [REG_AW-1:0]         ex_load_rd;
    logic                      if_stall_i;
    logic                      ex_stall_i;
    logic                      mem_stall_i;
    logic                      flush_i;
    logic                      if_id_stall_o;
    logic                      id_ex_stall_o;
    logic                      ex_mem_stall_o;
    logic                      id_ex_bubble_o;
    logic                      stall_timeout_o;
`ifdef HAZARD_PERF_EN
    logic [31:0]               lu_cnt_o;
    logic [31:0]               mem_cnt_o;
`endif

    hazard_ctrl #(
        .N_ISSUE (N_ISSUE),
        .REG_AW  (REG_AW),
        .LOAD_LAT(LOAD_LAT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .de_valid       (de_valid),
        .de_rs          (de_rs),
        .de_rt          (de_rt),
        .ex_load_valid  (ex_load_valid),
        .ex_load_rd     (ex_load_rd),
        .if_stall_i     (if_stall_i),
        .ex_stall_i     (ex_stall_i),
        .mem_stall_i    (mem_stall_i),
        .flush_i        (flush_i),
        .if_id_stall_o  (if_id_stall_o),
        .id_ex_stall_o  (id_ex_stall_o),
        .ex_mem_stall_o (ex_mem_stall_o),
        .id_ex_bubble_o (id_ex_bubble_o),
`ifdef HAZARD_PERF_EN
        .lu_cnt_o       (lu_cnt_o),
        .mem_cnt_o      (mem_cnt_o),
`endif
        .stall_timeout_o(stall_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Observed vector order: {if_id_stall, id_ex_stall, ex_mem_stall, bubble, timeout}
    task automatic step(input string tag, input logic [4:0] exp);
        exp_t       e;
        logic [4:0] obs;
        exp_q.push_back('{tag, exp});
        @(negedge clk);
        e   = exp_q.pop_front();
        obs = {if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, id_ex_bubble_o, stall_timeout_o};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        de_valid      = '0;
        de_rs         = '0;
        de_rt         = '0;
        ex_load_valid = 1'b0;
        ex_load_rd    = '0;
        if_stall_i    = 1'b0;
        ex_stall_i    = 1'b0;
        mem_stall_i   = 1'b0;
        flush_i       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not finish, errors=%0d", errors);
        $fatal(1, "time limit");
    end

    initial begin
        idle();
        rst           = 1'b1;
        ex_load_valid = 1'b1;
        ex_load_rd    = 5'd5;
        de_valid      = 2'b01;
        de_rs[4:0]    = 5'd5;
        if_stall_i    = 1'b1;
        mem_stall_i   = 1'b1;
        step("rst_force_a", 5'b00000);
        step("rst_force_b", 5'b00000);

        // First cycle after reset: scoreboard must be empty.
        rst = 1'b0;
        idle();
        de_valid   = 2'b01;
        de_rs[4:0] = 5'd5;
        step("post_rst", 5'b00000);

        // Load-use through EX then through entry1.
        ex_load_valid = 1'b1;
        ex_load_rd    = 5'd5;
        step("lu_c0", 5'b10010);
        ex_load_valid = 1'b0;
        step("lu_c1", 5'b10010);
        step("lu_c2", 5'b00000);
`ifdef HAZARD_PERF_EN
        checks++;
        assert (lu_cnt_o === 32'd2) else begin
            errors++;
            $error("FAIL lu_cnt: observed=%0d expected=2", lu_cnt_o);
        end
`endif

        // Register zero and invalid slots never match.
        idle();
        ex_load_valid = 1'b1;
        ex_load_rd    = 5'd0;
        de_valid      = 2'b10;
        step("rd_zero", 5'b00000);
        ex_load_rd    = 5'd5;
        de_valid      = 2'b00;
        de_rt[9:5]    = 5'd5;
        step("slot_invalid", 5'b00000);
        idle();
        step("drain_a", 5'b00000);
        ex_load_valid = 1'b1;
        ex_load_rd    = 5'd6;
        de_valid      = 2'b10;
        de_rt[9:5]    = 5'd6;
        step("rt_slot1", 5'b10010);
        idle();
        step("drain_b", 5'b00000);

        // Scoreboard held across a memory stall.
        ex_load_valid = 1'b1;
        ex_load_rd    = 5'd7;
        step("load7", 5'b00000);
        ex_load_valid = 1'b0;
        de_valid      = 2'b01;
        de_rs[4:0]    = 5'd7;
        mem_stall_i   = 1'b1;
        step("mem_hold_1", 5'b11100);
        step("mem_hold_2", 5'b11100);
        step("mem_hold_3", 5'b11100);
        mem_stall_i   = 1'b0;
        step("mem_release", 5'b10010);
`ifdef HAZARD_PERF_EN
        checks++;
        assert (mem_cnt_o === 32'd3) else begin
            errors++;
            $error("FAIL mem_cnt: observed=%0d expected=3", mem_cnt_o);
        end
`endif
        step("after_release", 5'b00000);

        // Flush masks load_use but not scoreboard capture.
        idle();
        ex_load_valid = 1'b1;
        ex_load_rd    = 5'd9;
        de_valid      = 2'b01;
        de_rs[4:0]    = 5'd9;
        flush_i       = 1'b1;
        step("flush", 5'b00000);
        ex_load_valid = 1'b0;
        flush_i       = 1'b0;
        step("post_flush", 5'b10010);
        idle();
        step("drain_c", 5'b00000);

        // EX stall suppresses the bubble; fetch stall alone.
        ex_load_valid = 1'b1;
        ex_load_rd    = 5'd3;
        de_valid      = 2'b01;
        de_rs[4:0]    = 5'd3;
        ex_stall_i    = 1'b1;
        step("exstall_lu", 5'b10000);
        idle();
        step("drain_d", 5'b00000);
        if_stall_i = 1'b1;
        step("if_stall", 5'b10000);
        idle();
        step("drain_e", 5'b00000);

        // Watchdog: 7 + gap + 7 never trips; 8 trips and sticks until reset.
        ex_stall_i = 1'b1;
        repeat (7) step("wd_run_a", 5'b10000);
        ex_stall_i = 1'b0;
        step("wd_gap_a", 5'b00000);
        ex_stall_i = 1'b1;
        repeat (7) step("wd_run_b", 5'b10000);
        ex_stall_i = 1'b0;
        step("wd_gap_b", 5'b00000);
        ex_stall_i = 1'b1;
        repeat (8) step("wd_run_c", 5'b10000);
        ex_stall_i = 1'b0;
        step("wd_set", 5'b00001);
        step("wd_sticky", 5'b00001);
        rst = 1'b1;
        step("wd_rst_force", 5'b00000);
        rst = 1'b0;
        step("wd_cleared", 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter N_ISSUE, default 2, decode slots checked per cycle (1..4).
REQ-002 SHALL have parameter REG_AW, default 5, register address width.
REQ-003 SHALL have parameter LOAD_LAT, default 2, cycles a load result stays unavailable, counting its EX cycle (1..4).
REQ-004 SHALL have parameter TIMEOUT, default 1024, consecutive-stall cycles that trip the watchdog (>=2).
REQ-005 SHALL have one clock and a synchronous, active-high reset:
  clk  in  1  clock, rising edge
  rst  in  1  synchronous active-high reset
  de_valid  in  N_ISSUE  decode slot i valid
  de_rs  in  N_ISSUE*REG_AW  slot i rs at bits [i*REG_AW +: REG_AW]
  de_rt  in  N_ISSUE*REG_AW  slot i rt, same packing
  ex_load_valid  in  1  a load occupies EX
  ex_load_rd  in  REG_AW  destination of that load
  if_stall_i  in  1  fetch not ready
  ex_stall_i  in  1  multicycle EX op busy
  mem_stall_i  in  1  data memory not ready
  flush_i  in  1  kill IF/ID contents this cycle
  if_id_stall_o  out  1  hold PC and IF/ID
  id_ex_stall_o  out  1  hold ID/EX
  ex_mem_stall_o  out  1  hold EX/MEM
  id_ex_bubble_o  out  1  load NOP into ID/EX
  stall_timeout_o  out  1  sticky watchdog flag

Function
REQ-006 SHALL keep scoreboard entries k=1..LOAD_LAT-1, each {pend_v, pend_rd}; no entries when LOAD_LAT=1.
REQ-007 SHALL, when ex_mem_stall_o=0, shift: entry1 <= {ex_load_valid, ex_load_rd}; entry k <= entry k-1; oldest entry discarded.
REQ-008 SHALL hold every entry unchanged while ex_mem_stall_o=1.
REQ-009 SHALL leave the scoreboard unaffected by flush_i (tracked loads are older than the flush point).
REQ-010 SHALL define a slot match: de_valid[i]=1, source (rs or rt) nonzero and equal to ex_load_rd with ex_load_valid=1, or equal to pend_rd of any entry with pend_v=1.
REQ-011 SHALL set load_use = (any slot match) AND NOT flush_i, combinationally in the same cycle.
REQ-012 SHALL drive if_id_stall_o = if_stall_i | ex_stall_i | mem_stall_i | load_use.
REQ-013 SHALL drive id_ex_stall_o = ex_mem_stall_o = mem_stall_i.
REQ-014 SHALL drive id_ex_bubble_o = load_use & ~mem_stall_i & ~ex_stall_i.
REQ-015 SHALL count consecutive cycles with if_id_stall_o=1 in a saturating counter cleared on any cycle with if_id_stall_o=0.
REQ-016 SHALL set stall_timeout_o on the clock edge at which the counter reaches TIMEOUT and hold it at 1 until rst, regardless of later stall state.
REQ-017 SHALL size the watchdog counter $clog2(TIMEOUT+1) bits and never wrap it.

Reset
REQ-018 SHALL, on a rising clk with rst=1, clear all pend_v, pend_rd, the watchdog counter, stall_timeout_o and any performance counters.
REQ-019 SHALL force all outputs to 0 while rst=1, independent of other inputs.
REQ-020 SHALL, on the first cycle after rst deasserts, compute outputs from inputs and an empty scoreboard only.

Configuration
REQ-021 SHALL, with macro HAZARD_PERF_EN defined, add outputs lu_cnt_o (out, 32, cycles with load_use=1) and mem_cnt_o (out, 32, cycles with mem_stall_i=1), both wrapping modulo 2^32, reset to 0.
REQ-022 SHALL, without HAZARD_PERF_EN, omit both ports and counters; all other behaviour identical.

Verification (N_ISSUE=2, REG_AW=5, LOAD_LAT=2, TIMEOUT=8)
REQ-023 SHALL cover: ex_load_valid=1, ex_load_rd=5, slot0 rs=5 held -> cycle0 if_id_stall_o=1 and id_ex_bubble_o=1; cycle1 (entry1 rd=5) both 1 again; cycle2 with no new load both 0.
REQ-024 SHALL cover: ex_load_rd=0, slot1 rt=0 valid -> no stall; slot1 rt=5 with de_valid[1]=0 -> no stall.
REQ-025 SHALL cover: entry1 holds rd=7, mem_stall_i=1 for 3 cycles with slot0 rs=7 -> all three stalls 1, bubble 0, entry1 still rd=7 after release and bubble 1 on the release cycle.
REQ-026 SHALL cover: slot0 rs matching ex_load_rd=9 with flush_i=1 -> if_id_stall_o=0, bubble 0; next cycle without flush, entry1 rd=9 still matches -> stall 1.
REQ-027 SHALL cover: ex_stall_i=1 for 8 cycles -> stall_timeout_o=1 after the 8th edge, remains 1 after ex_stall_i drops, clears only on rst; 7 cycles then 1 idle cycle then 7 cycles -> never sets.
REQ-028 SHALL cover, with HAZARD_PERF_EN: scenario REQ-023 -> lu_cnt_o=2; lu_cnt_o preloaded to 0xFFFFFFFF plus one load_use cycle -> 0.
